// File: rtl/if_stage_reg.sv
// Instruction fetch stage with IF/ID pipeline register, imem handshake, stall and flush handling.
// Optional fetch/bubble counters are enabled with `define IF_FETCH_STATS_EN.
module if_stage_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        BranchFlush,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] NextInstruct_out,
  output logic        Valid_ID
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic        load_real;
  logic        load_bubble;
  logic [31:0] load_word;

  assign pc_plus4 = pc + 32'd4;

  // What the IF/ID register takes this cycle: a real word, a bubble, or nothing (hold).
  always_comb begin
    load_real   = 1'b0;
    load_bubble = 1'b0;
    load_word   = imem_rdata;
    if (BranchFlush) begin
      load_bubble = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (!Stall) begin
            load_real   = imem_ready;
            load_bubble = !imem_ready;
          end
        end
        HOLD: begin
          load_real = !Stall;
          load_word = hold_buf;
        end
        KILL:    load_bubble = !Stall;
        default: load_bubble = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      imem_addr        <= RESET_PC;
      imem_req         <= 1'b1;
      hold_buf         <= 32'd0;
      redirect_pc      <= 32'd0;
      Instruction_ID   <= NOP_INSTR;
      PC_ID            <= 32'd0;
      NextInstruct_out <= 32'd0;
      Valid_ID         <= 1'b0;
    end else begin
      if (load_real) begin
        Instruction_ID   <= load_word;
        PC_ID            <= pc;
        NextInstruct_out <= pc_plus4;
        Valid_ID         <= 1'b1;
      end else if (load_bubble) begin
        Instruction_ID   <= NOP_INSTR;
        PC_ID            <= 32'd0;
        NextInstruct_out <= 32'd0;
        Valid_ID         <= 1'b0;
      end

      if (BranchFlush) begin
        // A pending request must stay stable, so an unacknowledged flush parks the target.
        if (state == HOLD || imem_ready) begin
          pc        <= BranchTarget;
          imem_addr <= BranchTarget;
          state     <= FETCH;
          imem_req  <= 1'b1;
        end else begin
          redirect_pc <= BranchTarget;
          state       <= KILL;
          imem_req    <= 1'b1;
        end
      end else begin
        case (state)
          FETCH: begin
            if (imem_ready) begin
              if (!Stall) begin
                pc        <= pc_plus4;
                imem_addr <= pc_plus4;
              end else begin
                hold_buf <= imem_rdata;
                state    <= HOLD;
                imem_req <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (!Stall) begin
              pc        <= pc_plus4;
              imem_addr <= pc_plus4;
              state     <= FETCH;
              imem_req  <= 1'b1;
            end
          end
          KILL: begin
            if (imem_ready) begin
              pc        <= redirect_pc;
              imem_addr <= redirect_pc;
              state     <= FETCH;
            end
          end
          default: begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef IF_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      FetchCount  <= 32'd0;
      BubbleCount <= 32'd0;
    end else begin
      if (load_real)   FetchCount  <= FetchCount + 32'd1;
      if (load_bubble) BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage_reg.md
Name: if_stage_reg

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID/EX register.
- Owns the PC and runs the instruction-memory request/ready handshake.
- Applies load-use stalls and branch flushes from downstream.
- Presents Instruction_ID, PC_ID and NextInstruct_out (PC+4) to the decode stage, whose outputs feed ID/EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  reset, synchronous, active-low (rst==0 at posedge resets).
Stall  input  1  hold PC and IF/ID contents (load-use hazard).
BranchFlush  input  1  taken branch/jump; redirect fetch, bubble IF/ID.
BranchTarget  input  32  redirect address, valid with BranchFlush.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address; stable while imem_req high and not acknowledged.
imem_rdata  input  32  instruction word, valid when imem_ready high.
imem_ready  input  1  transfer completes in any cycle with imem_req & imem_ready.
Instruction_ID  output  32  registered instruction.
PC_ID  output  32  registered PC of Instruction_ID.
NextInstruct_out  output  32  registered PC_ID+4.
Valid_ID  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset: PC=RESET_PC, fetch_addr=RESET_PC, state=FETCH.
- Reset clears hold buffer and redirect_pc.
- Reset drives Instruction_ID=NOP_INSTR, PC_ID=0, NextInstruct_out=0, Valid_ID=0.
- Reset overrides every other input, including mid-handshake; the outstanding request is abandoned.
- imem_req=1 in FETCH and KILL, 0 in HOLD. imem_addr=fetch_addr register.
- Latency: zero-wait memory gives the word on Instruction_ID one clock after the ready cycle. Sustained throughput is 1 instruction/clock.
- Priority each cycle: rst > BranchFlush > Stall > normal.
- FETCH:
  - ready & !Stall & !flush: IF/ID <= {rdata, PC, PC+4, valid=1}; PC, fetch_addr <= PC+4.
  - ready & Stall & !flush: hold_buf <= rdata; go HOLD; IF/ID unchanged.
  - !ready & !flush: IF/ID loads bubble if !Stall, else holds.
  - flush & ready: word discarded; PC, fetch_addr <= BranchTarget; stay FETCH.
  - flush & !ready: redirect_pc <= BranchTarget; go KILL. fetch_addr unchanged (handshake stability).
- HOLD:
  - !Stall & !flush: IF/ID <= {hold_buf, PC, PC+4, 1}; PC, fetch_addr <= PC+4; go FETCH.
  - Stall: everything held.
  - flush: hold_buf discarded; PC, fetch_addr <= BranchTarget; go FETCH.
- KILL:
  - Old request kept stable until ready; the returned word is always discarded.
  - On ready: PC, fetch_addr <= redirect_pc; go FETCH.
  - A further flush in KILL overwrites redirect_pc (latest wins). If it coincides with ready, BranchTarget is used directly.
- Any flush: IF/ID <= {NOP_INSTR, 0, 0, valid=0} regardless of Stall.
- In KILL with !Stall, IF/ID loads bubble.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. PC[1:0] is not checked.

Optional Feature:
IF_FETCH_STATS_EN
- Defined: adds outputs FetchCount[31:0] and BubbleCount[31:0], both reset to 0 and wrapping modulo 2^32.
  - FetchCount increments on each cycle IF/ID loads valid=1.
  - BubbleCount increments on each cycle IF/ID loads valid=0 (excluding reset and held cycles).
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then zero-wait memory returning addr+0x100 -> Instruction_ID sequence 0x100, 0x104, 0x108 with PC_ID 0, 4, 8, NextInstruct_out 4, 8, 12, Valid_ID=1 every cycle.
- Memory ready delayed 2 cycles at addr 0x8 -> imem_addr=0x8 stable for 3 cycles; Valid_ID=0 for 2 cycles, then instruction from 0x8.
- Stall 3 cycles coinciding with ready -> FSM enters HOLD, imem_req=0, IF/ID frozen. On release the buffered word appears once; no duplicate and no skip.
- BranchFlush, BranchTarget=0x40 while request to 0x10 pending -> addr stays 0x10 until ready. Word discarded; next request at 0x40; Valid_ID=0 until the 0x40 word arrives.
- Flush and Stall asserted together in HOLD -> Valid_ID=0, Instruction_ID=NOP_INSTR, next fetch at BranchTarget.
- rst=0 mid-KILL -> next cycle imem_addr=RESET_PC, all outputs at reset values; counters at 0 with IF_FETCH_STATS_EN.
